dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (port P) and the host loader (port L).
//  The loader preloads and dumps data memory while the processor runs.
//  Fixed P priority, bounded by a loader anti-starvation counter and an optional loader lock for block transfers.
//  Sits between PipelineProcessor's MEM stage and the data_memory array; drives p_stall into the pipeline hazard logic.
// PARAMETERS
//  AW        8   data memory address width
//  DW        16  data word width
//  MAX_WAIT  4   consecutive denied loader cycles before the loader is forced to win (>=1)
//  MAX_LOCK  8   max consecutive loader grants under l_lock (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  p_req      in   1   pipeline access request; held with p_we/p_addr/p_wdata stable until p_gnt
//  p_we       in   1   1 = STORE, 0 = LOAD
//  p_addr     in   AW  pipeline address
//  p_wdata    in   DW  pipeline store data
//  p_gnt      out  1   access performed this cycle (combinational)
//  p_stall    out  1   p_req & ~p_gnt; freezes pipeline stages up to MEM
//  p_rvalid   out  1   registered; high the cycle after a granted P read
//  p_rdata    out  DW  read data, valid with p_rvalid
//  l_req      in   1   loader request; same hold rule as p_req
//  l_we       in   1   loader write enable
//  l_addr     in   AW  loader address
//  l_wdata    in   DW  loader write data
//  l_lock     in   1   sampled at an L grant; requests continued ownership for a burst
//  l_gnt      out  1   loader access performed this cycle
//  l_rvalid   out  1   registered; high the cycle after a granted L read
//  l_rdata    out  DW  read data, valid with l_rvalid
//  mem_en     out  1   memory access strobe (= p_gnt | l_gnt)
//  mem_we     out  1   memory write strobe
//  mem_addr   out  AW  memory address, muxed by winner
//  mem_wdata  out  DW  memory write data, muxed by winner
//  mem_rdata  in   DW  synchronous read data, valid one cycle after mem_en & ~mem_we
// BEHAVIOUR
//  Reset:
//   - state=ARB; wait_cnt=0; lock_cnt=0.
//   - p_rvalid=l_rvalid=0; p_rdata=l_rdata=0.
//   - While reset is high, p_gnt=l_gnt=mem_en=mem_we=0; p_stall=p_req.
//   - Reset mid-operation drops any pending rvalid on the next edge.
//  Mutual exclusion: p_gnt & l_gnt is never 1. At most one memory access per cycle.
//  State ARB:
//   - L wins if l_req & (~p_req | wait_cnt==MAX_WAIT); otherwise P wins if p_req.
//   - wait_cnt: +1 when l_req & ~l_gnt (saturates at MAX_WAIT); 0 on l_gnt or when ~l_req.
//   - L grant with l_lock=1 and MAX_LOCK>1: go to LOCK, lock_cnt=1.
//  State LOCK:
//   - l_req has absolute priority; P is stalled.
//   - Each L grant increments lock_cnt.
//   - Return to ARB when any of these holds: l_lock=0 at a grant, lock_cnt==MAX_LOCK after a grant, or ~l_req.
//   - On return to ARB, P wins the next cycle if p_req, regardless of wait_cnt.
//  Reads:
//   - A winner with we=0 registers rd_owner.
//   - Next cycle, the matching *_rvalid=1 and *_rdata=mem_rdata; the other port's rdata holds its value.
//   - Reads are back-to-back capable: one result per cycle, no bubbles.
//  Same-address write then read (either port order): the read returns the new data.
//   - Guaranteed by the memory's write-before-read ordering across cycles; no bypass logic.
//  Latency: grant 0 cycles (same cycle as req when winning); read data 1 cycle after grant.
// STRUCTURE
//  Shared package dmem_pkg:
//   - arb_state_e {ARB, LOCK}
//   - owner_e {OWN_P, OWN_L}
//   - AW/DW defaults
//  One sub-module, dmem_arb_fsm: state, wait_cnt, lock_cnt, grant decision.
//  Top level holds address/data muxing and registered read-return steering.
// TESTING
//  1 Reset: hold reset 2 cycles with p_req=l_req=1 -> no grants, mem_en=0, p_stall=1, rvalids 0.
//  2 P-only read: data_memory[5]=99, p_req read addr 5 -> p_gnt same cycle; next cycle p_rvalid=1, p_rdata=99.
//  3 Contention: p_req and l_req held high with continuous P reads.
//    -> P wins 4 cycles, L granted on cycle 5, wait_cnt back to 0, pattern repeats; p_stall=1 exactly on L cycles.
//  4 Lock burst: l_lock=1, l_req held, writes to addr 0..9, p_req=1.
//    -> 8 consecutive L grants (addr 0..7), then P granted, then arbitration resumes.
//  5 Write/read ordering: L writes 20 to addr 6 in cycle n, P reads addr 6 in cycle n+1 -> p_rdata=20 at n+2.
//  6 Reset mid-burst: assert reset in LOCK with a granted L read -> next cycle l_rvalid=0, state ARB, counters 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory arbiter.
// Arbiter states, read owner tags, default address/data widths.
package dmem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Grant decision for the pipeline (P) and loader (L) ports.
// Ports: clk, reset, p_req, l_req, l_lock in; p_gnt, l_gnt out (combinational).
module dmem_arb_fsm
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic p_req,
    input  logic l_req,
    input  logic l_lock,
    output logic p_gnt,
    output logic l_gnt
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);
    localparam bit LOCK_EN = (MAX_LOCK > 1);

    arb_state_e    state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [LW-1:0] lock_cnt, lock_n;
    // One-shot: P owns the first cycle after a burst ends.
    logic          p_first, p_first_n;

    always_comb begin
        p_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            unique case (state)
                ARB: begin
                    if (p_first && p_req) begin
                        p_gnt = 1'b1;
                    end else begin
                        l_gnt = l_req &
                                (~p_req | (wait_cnt == WAIT_MAX));
                        p_gnt = p_req & ~l_gnt;
                    end
                end
                LOCK: l_gnt = l_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        lock_n    = lock_cnt;
        p_first_n = 1'b0;
        unique case (state)
            ARB: begin
                lock_n = '0;
                if (l_req && !l_gnt) begin
                    if (wait_cnt != WAIT_MAX)
                        wait_n = wait_cnt + 1'b1;
                end else begin
                    wait_n = '0;
                end
                if (l_gnt && l_lock && LOCK_EN) begin
                    state_n = LOCK;
                    lock_n  = LW'(1);
                end
            end
            LOCK: begin
                wait_n = '0;
                lock_n = lock_cnt + LW'(l_gnt);
                if (!l_req ||
                    (l_gnt && (!l_lock || lock_n == LOCK_MAX))) begin
                    state_n   = ARB;
                    lock_n    = '0;
                    p_first_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            wait_cnt <= '0;
            lock_cnt <= '0;
            p_first  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            lock_cnt <= lock_n;
            p_first  <= p_first_n;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between MEM stage (P) and host loader (L).
// Ports: p_* pipeline side, l_* loader side, mem_* memory side, clk/reset.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_stall,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          rd_vld;
    owner_e        rd_own;
    logic [DW-1:0] p_hold;
    logic [DW-1:0] l_hold;

    dmem_arb_fsm #(
        .MAX_WAIT (MAX_WAIT),
        .MAX_LOCK (MAX_LOCK)
    ) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .p_req  (p_req),
        .l_req  (l_req),
        .l_lock (l_lock),
        .p_gnt  (p_gnt),
        .l_gnt  (l_gnt)
    );

    assign p_stall   = p_req & ~p_gnt;
    assign mem_en    = p_gnt | l_gnt;
    assign mem_we    = (p_gnt & p_we) | (l_gnt & l_we);
    assign mem_addr  = l_gnt ? l_addr : p_addr;
    assign mem_wdata = l_gnt ? l_wdata : p_wdata;

    assign p_rvalid = rd_vld & (rd_own == OWN_P);
    assign l_rvalid = rd_vld & (rd_own == OWN_L);

    // Memory output is live only in the return cycle; the hold
    // registers keep each port's last result stable afterwards.
    assign p_rdata = p_rvalid ? mem_rdata : p_hold;
    assign l_rdata = l_rvalid ? mem_rdata : l_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_own <= OWN_P;
            p_hold <= '0;
            l_hold <= '0;
        end else begin
            rd_vld <= mem_en & ~mem_we;
            rd_own <= l_gnt ? OWN_L : OWN_P;
            if (p_rvalid)
                p_hold <= mem_rdata;
            if (l_rvalid)
                l_hold <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a rule-level arbitration and memory model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int ML = 8;

    logic          clk;
    logic          reset;
    logic          preload;
    logic          p_req, p_we, l_req, l_we, l_lock;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata;
    logic          p_gnt, p_stall, p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          l_gnt, l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] tbmem [256];
    logic [DW-1:0] refmem [256];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // model state: loader denial streak, burst tracking, read returns
    int            m_wait;
    bit            m_burst;
    int            m_n;
    bit            m_pfirst;
    bit            m_rvp, m_rvl;
    logic [DW-1:0] m_prd, m_lrd;
    bit            eg_p, eg_l;
    bit            g_p, g_l;

    dmem_arbiter #(
        .AW (AW), .DW (DW), .MAX_WAIT (MW), .MAX_LOCK (ML)
    ) dut (
        .clk (clk), .reset (reset),
        .p_req (p_req), .p_we (p_we), .p_addr (p_addr),
        .p_wdata (p_wdata), .p_gnt (p_gnt), .p_stall (p_stall),
        .p_rvalid (p_rvalid), .p_rdata (p_rdata),
        .l_req (l_req), .l_we (l_we), .l_addr (l_addr),
        .l_wdata (l_wdata), .l_lock (l_lock), .l_gnt (l_gnt),
        .l_rvalid (l_rvalid), .l_rdata (l_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int i);
        if (i == 5)
            return 16'd99;
        return 16'(i * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++)
                tbmem[i] <= init_val(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we)
                tbmem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= tbmem[mem_addr];
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit           e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        eg_p = 1'b0;
        eg_l = 1'b0;
        if (!reset) begin
            if (m_burst) begin
                eg_l = l_req;
            end else if (m_pfirst && p_req) begin
                eg_p = 1'b1;
            end else begin
                eg_l = l_req && (!p_req || m_wait >= MW);
                eg_p = p_req && !eg_l;
            end
        end
        e_we   = eg_p ? p_we : (eg_l ? l_we : 1'b0);
        e_addr = eg_l ? l_addr : p_addr;
        e_wd   = eg_l ? l_wdata : p_wdata;
        chk("p_gnt", 32'(p_gnt), 32'(eg_p));
        chk("l_gnt", 32'(l_gnt), 32'(eg_l));
        chk("p_stall", 32'(p_stall), 32'(p_req && !eg_p));
        chk("mem_en", 32'(mem_en), 32'(eg_p || eg_l));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (eg_p || eg_l)
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we)
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("p_rvalid", 32'(p_rvalid), 32'(m_rvp));
        chk("l_rvalid", 32'(l_rvalid), 32'(m_rvl));
        chk("p_rdata", 32'(p_rdata), 32'(m_prd));
        chk("l_rdata", 32'(l_rdata), 32'(m_lrd));
        g_p = p_gnt;
        g_l = l_gnt;
        @(posedge clk);
        if (reset) begin
            m_wait = 0; m_burst = 0; m_n = 0; m_pfirst = 0;
            m_rvp = 0; m_rvl = 0; m_prd = '0; m_lrd = '0;
        end else begin
            m_rvp = eg_p && !p_we;
            m_rvl = eg_l && !l_we;
            if (m_rvp) m_prd = refmem[p_addr];
            if (m_rvl) m_lrd = refmem[l_addr];
            if (eg_p && p_we) refmem[p_addr] = p_wdata;
            if (eg_l && l_we) refmem[l_addr] = l_wdata;
            if (m_burst) begin
                m_wait = 0;
                if (eg_l) m_n++;
                if (!l_req || (eg_l && (!l_lock || m_n == ML))) begin
                    m_burst  = 0;
                    m_n      = 0;
                    m_pfirst = 1;
                end
            end else begin
                m_pfirst = 0;
                if (l_req && !eg_l)
                    m_wait = (m_wait < MW) ? m_wait + 1 : MW;
                else
                    m_wait = 0;
                if (eg_l && l_lock && ML > 1) begin
                    m_burst = 1;
                    m_n     = 1;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [9:0]  mask3;
        logic [13:0] mask4;
        bit          got;
        reset = 1'b1; preload = 1'b1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'd5; p_wdata = '0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'd3; l_wdata = '0;
        l_lock = 1'b0;
        m_wait = 0; m_burst = 0; m_n = 0; m_pfirst = 0;
        m_rvp = 0; m_rvl = 0; m_prd = '0; m_lrd = '0;
        for (int i = 0; i < 256; i++)
            refmem[i] = init_val(i);
        @(posedge clk);
        #1 preload = 1'b0;

        // reset held with both requesting
        step();
        step();
        chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);

        // P-only read of addr 5
        reset = 1'b0;
        l_req = 1'b0;
        step();
        chk("p_only_gnt", 32'(g_p), 32'd1);
        chk("p_only_rvalid", 32'(p_rvalid), 32'd1);
        chk("p_only_rdata", 32'(p_rdata), 32'd99);

        // contention: loader wins every fifth cycle
        l_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            mask3[i] = g_l;
        end
        chk("contention_mask", 32'(mask3), 32'h210);

        // locked burst of writes
        l_lock = 1'b1; l_we = 1'b1; l_addr = 8'd0; l_wdata = 16'd100;
        for (int i = 0; i < 14; i++) begin
            step();
            mask4[i] = g_l;
            if (g_l) begin
                l_addr  = l_addr + 1'b1;
                l_wdata = l_wdata + 1'b1;
            end
        end
        chk("lock_mask", 32'(mask4), 32'h0FF0);

        l_lock = 1'b0;
        p_req  = 1'b0;
        got    = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = g_l;
        end
        chk("drain_l", 32'(got), 32'd1);

        // loader write then pipeline read, same address
        l_req = 1'b1; l_we = 1'b1; l_addr = 8'd6; l_wdata = 16'd20;
        step();
        l_req = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'd6;
        step();
        p_req = 1'b0;
        chk("wr_rd_rvalid", 32'(p_rvalid), 32'd1);
        chk("wr_rd_rdata", 32'(p_rdata), 32'd20);

        // reset during a locked read burst
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'd1; l_lock = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst_mid_l_rdata", 32'(l_rdata), 32'd0);
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'd2;
        step();
        chk("rst_mid_p_wins", 32'(g_p), 32'd1);
        chk("rst_mid_l_loses", 32'(g_l), 32'd0);
        p_req = 1'b0;
        l_lock = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!p_req && $urandom_range(9) < 6) begin
                p_req   = 1'b1;
                p_we    = 1'($urandom_range(1));
                p_addr  = 8'($urandom_range(15));
                p_wdata = 16'($urandom);
            end
            if (!l_req && $urandom_range(9) < 5) begin
                l_req   = 1'b1;
                l_we    = 1'($urandom_range(1));
                l_addr  = 8'($urandom_range(15));
                l_wdata = 16'($urandom);
                l_lock  = ($urandom_range(9) < 3);
            end
            reset = ($urandom_range(99) == 0);
            step();
            if (g_p) p_req = 1'b0;
            if (g_l) l_req = 1'b0;
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
